mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the MIPS datapath. It consumes the two register-file read ports (rs, rt) in the execute stage and computes MULT/MULTU/DIV/DIVU over a fixed 33-cycle latency. Results go into architectural HI/LO registers, readable by MFHI/MFLO. It drives `busy_o` so the hazard logic can stall any instruction that touches HI/LO, or that issues another multiply/divide, until the result is ready.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `start_i`  in  1  begin the operation selected by `op_i`; sampled only in IDLE.
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `RSdata_i`  in  WIDTH  rs value: multiplicand or dividend; also the MTHI/MTLO source.
- `RTdata_i`  in  WIDTH  rt value: multiplier or divisor.
- `mthi_i`, `mtlo_i`  in  1  write `RSdata_i` into HI or LO; honoured only in IDLE.
- `busy_o`  out  1  high while an operation is in flight.
- `done_o`  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- `div_zero_o`  out  1  pulses together with `done_o` when a DIV/DIVU had a zero divisor.
- `hi_o`, `lo_o`  out  WIDTH  current HI and LO registers.

## Operation
- FSM has three states: IDLE, CALC, FIX.
- IDLE → CALC when `start_i`=1. On that edge:
  - latch the opcode;
  - latch operand magnitudes (absolute values for MULT/DIV);
  - latch the result signs;
  - set the iteration counter to 0.
- CALC executes one step per cycle; leaves for FIX when the counter reaches `WIDTH`-1.
  - Multiply: shift-add over a 2·WIDTH product register.
  - Divide: restoring shift-subtract, giving quotient and remainder.
- FIX applies the sign correction and writes HI/LO, then returns to IDLE.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Signed rules:
  - product sign = xor of operand signs;
  - quotient sign = xor of operand signs;
  - remainder sign = dividend sign;
  - −2^31 / −1 gives LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=original `RSdata_i`, `div_zero_o`=1. The operation still takes the full latency.
- While not IDLE: `start_i`, `mthi_i` and `mtlo_i` are ignored. HI/LO keep their old values until FIX.
- In IDLE, `mthi_i`/`mtlo_i` write on the edge. If `start_i` is on the same edge, the write happens and the operation still starts; FIX later overwrites HI/LO.
- Reset value of every output is 0, including HI and LO. Reset also sends the FSM to IDLE and the counter to 0.

## Timing
- Start accepted at edge N. `busy_o` (= state≠IDLE, decoded from the state register) is high for cycles N+1 … N+33.
- Edges N+1 … N+32 run the CALC steps. Edge N+33 runs FIX: HI/LO are written and `done_o`/`div_zero_o` are registered high for one cycle.
- Back-to-back: a `start_i` held high through the `done_o` cycle is accepted at edge N+34. Throughput is one operation per 34 cycles.
- MTHI/MTLO latency is 1: the value appears on `hi_o`/`lo_o` after the writing edge.
- `rst_i` asserted mid-operation, in any state:
  - `busy_o`, `done_o`, `div_zero_o`, `hi_o`, `lo_o` go to 0 immediately, without waiting for a clock;
  - the partial result is discarded and no `done_o` pulse follows;
  - the FSM restarts in IDLE after release.

## Structure
- Shared package holds:
  - opcode encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - the FSM state enum (IDLE, CALC, FIX);
  - the `WIDTH` default.
- A single module is sufficient. If split, the only natural sub-module is `mdu_sign_fix`: combinational negation/abs of operands and results.
- The counter is $clog2(WIDTH)+1 bits wide.

## Test plan
- MULT, RS=0xFFFFFFFE, RT=3 → at edge N+33: HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done_o` high for exactly 1 cycle, `busy_o` high for exactly 33 cycles.
- MULTU, RS=RT=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands → HI=0, LO=1.
- DIV, RS=0xFFFFFFF9 (−7), RT=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV, RS=0x80000000, RT=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU, RS=5, RT=0 → LO=0xFFFFFFFF, HI=5, `div_zero_o`=1 together with `done_o`.
- Two starts with `mthi_i`:
  - first start with MULTU 3×4, then `start_i` pulsed at cycle N+10 with different operands → ignored, result HI=0, LO=12;
  - next, `mthi_i`=1 in IDLE with RS=0x12345678 → `hi_o`=0x12345678 after one edge.
- `rst_i` pulsed asynchronously during CALC, counter ≈ 10 → outputs 0 before the next edge; no `done_o`; a new MULTU 2×2 afterwards gives LO=4.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// opcode encodings, FSM states and the default datapath width.
package mul_div_unit_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes and result signs on the
// way in, two's-complement correction of the raw HI/LO result on the way out.
module mdu_sign_fix
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   rs_i,
  input  logic [WIDTH-1:0]   rt_i,
  output logic [WIDTH-1:0]   abs_rs_o,
  output logic [WIDTH-1:0]   abs_rt_o,
  output logic               neg_lo_o,
  output logic               neg_hi_o,
  input  logic [1:0]         fix_op_i,
  input  logic               fix_neg_lo_i,
  input  logic               fix_neg_hi_i,
  input  logic [2*WIDTH-1:0] res_i,
  output logic [2*WIDTH-1:0] fixed_o
);

  logic rs_neg;
  logic rt_neg;

  always_comb begin
    rs_neg   = op_is_signed(op_i) & rs_i[WIDTH-1];
    rt_neg   = op_is_signed(op_i) & rt_i[WIDTH-1];
    abs_rs_o = rs_neg ? -rs_i : rs_i;
    abs_rt_o = rt_neg ? -rt_i : rt_i;
    neg_lo_o = rs_neg ^ rt_neg;
    // Remainder follows the dividend; a product is one 2W-wide value.
    neg_hi_o = op_is_div(op_i) ? rs_neg : (rs_neg ^ rt_neg);
  end

  always_comb begin
    fixed_o = res_i;
    if (op_is_div(fix_op_i)) begin
      fixed_o[2*WIDTH-1:WIDTH] = fix_neg_hi_i ? -res_i[2*WIDTH-1:WIDTH] : res_i[2*WIDTH-1:WIDTH];
      fixed_o[WIDTH-1:0]       = fix_neg_lo_i ? -res_i[WIDTH-1:0] : res_i[WIDTH-1:0];
    end else if (fix_neg_lo_i) begin
      fixed_o = -res_i;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, fixed latency.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] RSdata_i,
  input  logic [WIDTH-1:0] RTdata_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  mdu_state_e state_q, state_d;

  logic [1:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               zdiv_q, zdiv_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;
  logic               neg_lo_in;
  logic               neg_hi_in;
  logic [2*WIDTH-1:0] fixed_res;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .op_i         (op_i),
    .rs_i         (RSdata_i),
    .rt_i         (RTdata_i),
    .abs_rs_o     (abs_rs),
    .abs_rt_o     (abs_rt),
    .neg_lo_o     (neg_lo_in),
    .neg_hi_o     (neg_hi_in),
    .fix_op_i     (op_q),
    .fix_neg_lo_i (neg_lo_q),
    .fix_neg_hi_i (neg_hi_q),
    .res_i        (acc_q),
    .fixed_o      (fixed_res)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_CALC;
      ST_CALC: if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = (state_q != ST_IDLE);
  end

  // Single iteration steps. The 2W accumulator is {HI part, LO part} for both
  // operations: product shifts right, remainder/quotient pair shifts left.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opd_q});
    div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, opd_q}) : div_sh[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    zdiv_d   = zdiv_q;
    rs_d     = rs_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mthi_i) hi_d = RSdata_i;
        if (mtlo_i) lo_d = RSdata_i;
        if (start_i) begin
          op_d     = op_i;
          cnt_d    = '0;
          neg_lo_d = neg_lo_in;
          neg_hi_d = neg_hi_in;
          zdiv_d   = op_is_div(op_i) && (RTdata_i == '0);
          rs_d     = RSdata_i;
          if (op_is_div(op_i)) begin
            opd_d = abs_rt;
            acc_d = {{WIDTH{1'b0}}, abs_rs};
          end else begin
            opd_d = abs_rs;
            acc_d = {{WIDTH{1'b0}}, abs_rt};
          end
        end
      end
      ST_CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
      end
      ST_FIX: begin
        done_d = 1'b1;
        if (zdiv_q) begin
          hi_d = rs_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = fixed_res[2*WIDTH-1:WIDTH];
          lo_d = fixed_res[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      cnt_q    <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zdiv_q   <= 1'b0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      zdiv_q   <= zdiv_d;
      rs_q     <= rs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed bench for mul_div_unit against a cycle-level
// behavioural model built on plain 64-bit arithmetic.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  mul_div_unit #(
    .WIDTH (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .RSdata_i   (rs),
    .RTdata_i   (rt),
    .mthi_i     (mthi),
    .mtlo_i     (mtlo),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (o)
      OP_MULT: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      OP_MULTU: begin
        up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (o == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          lo = sq[31:0];
          hi = sr[31:0];
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          lo = uq[31:0];
          hi = ur[31:0];
        end
      end
    endcase
  endtask

  // Cycle-level model: 33 cycles busy after an accepted start, then one done cycle.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
      m_dz   = 1'b0;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (mthi) m_hi = rs;
      if (mtlo) m_lo = rs;
      if (start) begin
        ref_calc(op, rs, rt, p_hi, p_lo, p_dz);
        m_left = 33;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
        m_dz   = p_dz;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("busy", {31'b0, busy_o}, {31'b0, (m_left != 0)});
      chk("done", {31'b0, done_o}, {31'b0, m_done});
      chk("div_zero", {31'b0, div_zero_o}, {31'b0, m_dz});
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cycles);
    bit got_done;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
      if (busy_o) busy_cycles++;
      @(negedge clk);
    end
    chk("done_within_bound", {31'b0, got_done}, 32'd1);
  endtask

  task automatic directed(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
    int bc;
    do_op(o, a, b, bc);
    chk({name, "_hi"}, hi_o, exp_hi);
    chk({name, "_lo"}, lo_o, exp_lo);
    chk({name, "_dz"}, {31'b0, div_zero_o}, {31'b0, exp_dz});
    chk({name, "_busy_cycles"}, bc, 32'd33);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {31'b0, done_o}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom % 8)
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h1;
      4: v = $urandom % 16;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int  bc;
    bit  saw_done;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_dz", {31'b0, div_zero_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    directed("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    directed("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    directed("mult_m1sq", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
    directed("div_m7", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    directed("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    directed("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    directed("div_zero_s", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    directed("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);

    // Start while busy must be ignored, as must an MTLO in flight.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs = 32'd3; rt = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; op = OP_MULT; rs = 32'd7; rt = 32'd9; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) begin
        saw_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ignored_start_done", {31'b0, saw_done}, 32'd1);
    chk("ignored_start_hi", hi_o, 32'd0);
    chk("ignored_start_lo", lo_o, 32'd12);
    @(negedge clk);
    mthi = 1'b1; rs = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", hi_o, 32'h1234_5678);
    chk("mthi_lo_kept", lo_o, 32'd12);

    // Asynchronous reset mid-calculation.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs = 32'hDEAD_BEEF; rt = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("async_rst_hi", hi_o, 32'd0);
    chk("async_rst_lo", lo_o, 32'd0);
    chk("async_rst_done", {31'b0, done_o}, 32'd0);
    chk("async_rst_dz", {31'b0, div_zero_o}, 32'd0);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    chk("no_done_after_rst", {31'b0, saw_done}, 32'd0);
    directed("multu_2x2", OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0);

    // Back-to-back: start held high through the done cycle.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs = 32'd6; rt = 32'd7;
    repeat (36) @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", {31'b0, busy_o}, 32'd1);
    chk("b2b_first_lo", lo_o, 32'd42);
    repeat (40) @(negedge clk);

    // Random traffic, checked every cycle by the model comparison.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      start = ($urandom % 4) == 0;
      op    = 2'($urandom % 4);
      rs    = pick();
      rt    = pick();
      mthi  = ($urandom % 8) == 0;
      mtlo  = ($urandom % 8) == 0;
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(negedge clk);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
